fe_pack: RTL



---
 rtl/fe_pack.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fe_pack.sv
// fe_pack: freezes a 255-bit element (< 2p) to its canonical residue mod 2^255-19
// and streams the 32-byte little-endian encoding. Define FE_PACK_SIGN_EN to add sign_in.
`timescale 1ns/1ps
module fe_pack #(
  parameter int unsigned W = 17,
  parameter int unsigned N = 15,
  parameter int unsigned C = 19
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [N*W-1:0]   x_in,
`ifdef FE_PACK_SIGN_EN
  input  logic             sign_in,
`endif
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_last,
  output logic             done
);

  localparam int unsigned   XW     = N * W;
  localparam int unsigned   IW     = $clog2(N);
  localparam logic [IW-1:0] I_LAST = IW'(N - 1);
  localparam logic [W-1:0]  P_LO   = W'((1 << W) - C);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FREEZE,
    S_STREAM
  } state_t;

  state_t          state_q;
  logic [XW-1:0]   x_q;
  logic [XW-1:0]   diff_q;
  logic            borrow_q;
  logic [IW-1:0]   i_q;
  logic [4:0]      k_q;
  logic [XW:0]     enc_q;
  logic            sign_q;
  logic            busy_q;
  logic            valid_q;
  logic [7:0]      byte_q;
  logic            last_q;
  logic            done_q;

  logic [W-1:0]    p_word;
  logic [W:0]      d;
  logic [XW-1:0]   x_rot;
  logic [XW-1:0]   diff_d;
  logic [XW-1:0]   canon;
  logic [XW:0]     enc;
  logic            tag;

  // x rotates one word per FREEZE step; after N steps it is back in original order,
  // so the "keep x" choice can use the rotated value directly.
  always_comb begin
    p_word = (i_q == '0) ? P_LO : '1;
    d      = {1'b0, x_q[W-1:0]} - {{W{1'b0}}, borrow_q} - {1'b0, p_word};
    x_rot  = {x_q[W-1:0], x_q[XW-1:W]};
    diff_d = {d[W-1:0], diff_q[XW-1:W]};
    canon  = d[W] ? x_rot : diff_d;
`ifdef FE_PACK_SIGN_EN
    tag    = sign_q;
`else
    tag    = 1'b0;
`endif
    enc    = {tag, canon};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      i_q      <= '0;
      k_q      <= '0;
      enc_q    <= '0;
      sign_q   <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      byte_q   <= '0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            x_q      <= x_in;
`ifdef FE_PACK_SIGN_EN
            sign_q   <= sign_in;
`else
            sign_q   <= 1'b0;
`endif
            borrow_q <= 1'b0;
            i_q      <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_FREEZE;
          end
        end
        S_FREEZE: begin
          x_q      <= x_rot;
          diff_q   <= diff_d;
          borrow_q <= d[W];
          i_q      <= i_q + 1'b1;
          if (i_q == I_LAST) begin
            i_q     <= '0;
            k_q     <= '0;
            valid_q <= 1'b1;
            byte_q  <= enc[7:0];
            last_q  <= 1'b0;
            enc_q   <= {8'h00, enc[XW:8]};
            state_q <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (out_ready) begin
            if (k_q == 5'd31) begin
              k_q     <= '0;
              busy_q  <= 1'b0;
              valid_q <= 1'b0;
              byte_q  <= '0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              k_q    <= k_q + 1'b1;
              byte_q <= enc_q[7:0];
              enc_q  <= enc_q >> 8;
              last_q <= (k_q == 5'd30);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign out_byte  = byte_q;
  assign out_last  = last_q;
  assign done      = done_q;

endmodule
